// File: rtl/m_axi_read.sv
// AXI read-data deserializer: captures a 32-beat R-channel burst into 32 lane
// registers and hands the full vector to the compute array via valid/ready.
module m_axi_read #(
    parameter int unsigned LOAD_DATA_WIDTH = 32,
    parameter int unsigned AXI_WIDTH_DA    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [AXI_WIDTH_DA-1:0]       m_axi_memory_bus_RDATA,
    input  logic                          m_axi_memory_bus_RVALID,
    input  logic                          m_axi_memory_bus_RLAST,
    input  logic [1:0]                    m_axi_memory_bus_RRESP,
    output logic                          m_axi_memory_bus_RREADY,
    output logic [32*LOAD_DATA_WIDTH-1:0] load_data_o,
    output logic                          load_valid_o,
    input  logic                          load_ready_i,
    output logic [4:0]                    beat_cnt_o,
    output logic                          busy_o,
    output logic                          err_o
);

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t                     state, state_nxt;
    logic [LOAD_DATA_WIDTH-1:0] lanes [32];
    logic                       hs;
    logic                       last_beat;
    logic                       restart;

    assign hs        = m_axi_memory_bus_RVALID && m_axi_memory_bus_RREADY;
    assign last_beat = (beat_cnt_o == 5'd31);
    assign restart   = ((state == IDLE) && start_i) ||
                       ((state == HOLD) && load_ready_i && start_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_i) state_nxt = RECV;
            RECV: if (hs && last_beat) state_nxt = HOLD;
            HOLD: if (load_ready_i) state_nxt = start_i ? RECV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RREADY is taken straight from the state register, so it is glitch-free
    // and drops asynchronously with rst.
    always_comb begin
        m_axi_memory_bus_RREADY = (state == RECV);
        busy_o                  = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_o   <= '0;
            err_o        <= 1'b0;
            load_valid_o <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) lanes[i] <= '0;
        end else begin
            if (restart) begin
                beat_cnt_o <= '0;
                err_o      <= 1'b0;
            end
            if ((state == RECV) && hs) begin
                lanes[beat_cnt_o] <= m_axi_memory_bus_RDATA[LOAD_DATA_WIDTH-1:0];
                beat_cnt_o        <= beat_cnt_o + 5'd1;
                // RLAST must coincide exactly with beat 31; any non-OKAY response is also an error
                if ((m_axi_memory_bus_RRESP != 2'b00) ||
                    (m_axi_memory_bus_RLAST != last_beat))
                    err_o <= 1'b1;
                if (last_beat) load_valid_o <= 1'b1;
            end
            if ((state == HOLD) && load_ready_i) load_valid_o <= 1'b0;
        end
    end

    always_comb begin
        load_data_o = '0;
        for (int unsigned k = 0; k < 32; k++)
            load_data_o[k*LOAD_DATA_WIDTH +: LOAD_DATA_WIDTH] = lanes[k];
    end

endmodule

// File: tb/tb_m_axi_read.sv
// Scoreboard bench for m_axi_read: stimulus pushes expected lane vectors,
// a negedge monitor pops and compares whenever load_valid_o is presented.
module tb_m_axi_read;

    localparam int unsigned LW = 32;
    localparam int unsigned VW = 32 * LW;

    typedef struct {
        logic [VW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [31:0]   rdata = '0;
    logic          rvalid = 1'b0;
    logic          rlast = 1'b0;
    logic [1:0]    rresp = '0;
    logic          rready;
    logic [VW-1:0] load_data_o;
    logic          load_valid_o;
    logic          load_ready_i = 1'b0;
    logic [4:0]    beat_cnt_o;
    logic          busy_o;
    logic          err_o;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t cur;
    logic prev_v = 1'b0;

    m_axi_read #(.LOAD_DATA_WIDTH(LW), .AXI_WIDTH_DA(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .m_axi_memory_bus_RDATA(rdata), .m_axi_memory_bus_RVALID(rvalid),
        .m_axi_memory_bus_RLAST(rlast), .m_axi_memory_bus_RRESP(rresp),
        .m_axi_memory_bus_RREADY(rready),
        .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .load_ready_i(load_ready_i), .beat_cnt_o(beat_cnt_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic checkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t make_exp(input logic [31:0] base, input logic err);
        exp_t e;
        e.data = '0;
        for (int k = 0; k < 32; k++) e.data[k*LW +: LW] = base + 32'(k);
        e.err = err;
        return e;
    endfunction

    always @(negedge clk) begin
        if (load_valid_o) begin
            if (!prev_v) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_empty: got load_valid_o=1 expected no output");
                    cur = make_exp(32'hDEAD0000, 1'b0);
                end else begin
                    cur = sb.pop_front();
                    check("valid_err", 32'(err_o), 32'(cur.err));
                end
            end
            checkv("load_data", load_data_o, cur.data);
        end
        prev_v = load_valid_o;
    end

    task automatic do_start(input logic [31:0] base, input logic err_exp);
        sb.push_back(make_exp(base, err_exp));
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        check("start_rready", 32'(rready), 32'd1);
        check("start_busy", 32'(busy_o), 32'd1);
        check("start_beat", 32'(beat_cnt_o), 32'd0);
        check("start_err", 32'(err_o), 32'd0);
    endtask

    // Called at posedge+1 with RREADY already high.
    task automatic run_burst(input logic [31:0] base, input bit toggle, input int last_b,
                             input int resp_b, input int n_beats);
        int   k = 0;
        int   cyc = 0;
        logic hs;
        logic err_exp = 1'b0;
        while (k < n_beats && cyc < 500) begin
            rvalid = toggle ? ((cyc % 2) == 0) : 1'b1;
            rdata  = base + 32'(k);
            rlast  = (k == last_b);
            rresp  = (k == resp_b) ? 2'b10 : 2'b00;
            hs     = rvalid && rready;
            if (hs && k == 31) check("valid_before_last", 32'(load_valid_o), 32'd0);
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                if (rresp != 2'b00 || (rlast != (k == 31))) err_exp = 1'b1;
                k++;
                check("beat_err", 32'(err_o), 32'(err_exp));
            end
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = '0;
        if (k < n_beats) begin
            n_total++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", k, n_beats);
        end
        if (n_beats == 32) begin
            check("burst_cycles", 32'(cyc), toggle ? 32'd63 : 32'd32);
            check("end_valid", 32'(load_valid_o), 32'd1);
            check("end_rready", 32'(rready), 32'd0);
            check("end_beat", 32'(beat_cnt_o), 32'd0);
        end
    endtask

    task automatic accept();
        load_ready_i = 1'b1;
        @(posedge clk); #1 load_ready_i = 1'b0;
        check("accept_valid", 32'(load_valid_o), 32'd0);
        check("accept_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(load_valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_beat", 32'(beat_cnt_o), 32'd0);
        checkv("rst_data", load_data_o, '0);
        #21 rst = 1'b0;

        // continuous burst, lane k = k+1
        do_start(32'd1, 1'b0);
        run_burst(32'd1, 1'b0, 31, -1, 32);
        accept();

        // RVALID toggling every cycle
        do_start(32'd1, 1'b0);
        run_burst(32'd1, 1'b1, 31, -1, 32);
        accept();

        // RLAST on beat 15 and missing on beat 31
        do_start(32'h0000_0101, 1'b1);
        run_burst(32'h0000_0101, 1'b0, 15, -1, 32);
        accept();

        // SLVERR on beat 7, then a long hold followed by back-to-back start
        do_start(32'hA000_0000, 1'b1);
        check("err_cleared", 32'(err_o), 32'd0);
        run_burst(32'hA000_0000, 1'b0, 31, 7, 32);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_rready", 32'(rready), 32'd0);
            check("hold_valid", 32'(load_valid_o), 32'd1);
        end
        sb.push_back(make_exp(32'h0000_5500, 1'b0));
        load_ready_i = 1'b1; start_i = 1'b1;
        @(posedge clk); #1 load_ready_i = 1'b0; start_i = 1'b0;
        check("b2b_rready", 32'(rready), 32'd1);
        check("b2b_beat", 32'(beat_cnt_o), 32'd0);
        check("b2b_valid", 32'(load_valid_o), 32'd0);
        check("b2b_err", 32'(err_o), 32'd0);
        run_burst(32'h0000_5500, 1'b0, 31, -1, 32);
        accept();

        // reset after beat 20 discards the partial burst
        sb.push_back(make_exp(32'h0, 1'b0));
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        void'(sb.pop_back());
        run_burst(32'h7700_0000, 1'b0, 31, -1, 21);
        check("pre_rst_beat", 32'(beat_cnt_o), 32'd21);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rready", 32'(rready), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_beat", 32'(beat_cnt_o), 32'd0);
        checkv("mid_rst_data", load_data_o, '0);
        #1 rst = 1'b0;
        do_start(32'h1234_0000, 1'b0);
        run_burst(32'h1234_0000, 1'b0, 31, -1, 32);
        accept();

        repeat (3) @(posedge clk);
        #1 check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
